// File: rtl/mult_pipe_pkg.sv
// rtl/mult_pipe_pkg.sv - shared widths, config check and saturation limits for mult_pipe_hs
package mult_pipe_pkg;

  // Limits are built wide and then cut down to the width the caller needs.
  localparam int LIM_W = 128;

  // Width of the exact product of two operands.
  function automatic int prod_w(input int wa, input int wb);
    return wa + wb;
  endfunction

  // The selected result window must lie inside the full product.
  function automatic bit scale_fits(input int pw, input int ow, input int sh);
    return (ow >= 1) && (sh >= 0) && (ow + sh <= pw);
  endfunction

  // Largest value representable in ow bits (signed or unsigned).
  function automatic logic [LIM_W-1:0] sat_max(input int ow, input bit is_signed);
    return is_signed ? (LIM_W'(1) << (ow - 1)) - LIM_W'(1)
                     : (LIM_W'(1) << ow) - LIM_W'(1);
  endfunction

  // Smallest value representable in ow bits, two's complement in LIM_W bits.
  function automatic logic [LIM_W-1:0] sat_min(input int ow, input bit is_signed);
    return is_signed ? ~((LIM_W'(1) << (ow - 1)) - LIM_W'(1)) : '0;
  endfunction

endpackage

// File: rtl/mult_round_sat.sv
// rtl/mult_round_sat.sv - round-half-up, shift and clamp of one full product
module mult_round_sat
  import mult_pipe_pkg::*;
#(
  parameter int PROD_W = 40,
  parameter int OUT_W  = 40,
  parameter int SHIFT  = 0
) (
  input  logic [PROD_W-1:0] prod_i,
  input  logic              signed_i,
  output logic [OUT_W-1:0]  result_o,
  output logic              sat_o
);

  // Two spare bits: one for the sign of unsigned products, one for the rounding carry.
  localparam int XW = PROD_W + 2;
  localparam logic signed [XW-1:0] RND  = (XW'(1) << SHIFT) >> 1;
  localparam logic signed [XW-1:0] SMAX = XW'(sat_max(OUT_W, 1'b1));
  localparam logic signed [XW-1:0] UMAX = XW'(sat_max(OUT_W, 1'b0));
  localparam logic signed [XW-1:0] SMIN = XW'(sat_min(OUT_W, 1'b1));

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] shd;
  logic signed [XW-1:0] hi;
  logic signed [XW-1:0] lo;

  // Extend, add half an LSB of the result, shift down, then clamp to the output range.
  always_comb begin
    ext      = {{2{signed_i & prod_i[PROD_W-1]}}, prod_i};
    rnd      = ext + RND;
    shd      = rnd >>> SHIFT;
    hi       = signed_i ? SMAX : UMAX;
    lo       = signed_i ? SMIN : '0;
    result_o = shd[OUT_W-1:0];
    sat_o    = 1'b0;
    if (shd > hi) begin
      result_o = hi[OUT_W-1:0];
      sat_o    = 1'b1;
    end else if (shd < lo) begin
      result_o = lo[OUT_W-1:0];
      sat_o    = 1'b1;
    end
  end

endmodule

// File: rtl/mult_pipe_hs.sv
// rtl/mult_pipe_hs.sv - pipelined handshake multiplier with tag sideband; MULT_ROUND_SAT_EN adds round/saturate stage
module mult_pipe_hs
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH_A  = 8,
  parameter int WIDTH_B  = 32,
  parameter int OUT_W    = 40,
  parameter int SHIFT    = 0,
  parameter int PIPELINE = 4,
  parameter int TAG_W    = 4
) (
  input  logic               clock,
  input  logic               aclr,
  input  logic               signed_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] dataa,
  input  logic [WIDTH_B-1:0] datab,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               sat
);

  localparam int PW     = prod_w(WIDTH_A, WIDTH_B);
  localparam bit CFG_OK = scale_fits(PW, OUT_W, SHIFT) && (PIPELINE >= 1);

  if (!CFG_OK) begin : g_cfg_err
    $error("mult_pipe_hs: OUT_W+SHIFT must fit the product and PIPELINE must be >= 1");
  end

  logic               stall;
  logic               adv;
  logic               v_q;
  logic               se_q;
  logic [WIDTH_A-1:0] a_q;
  logic [WIDTH_B-1:0] b_q;
  logic [TAG_W-1:0]   t_q;
  logic [PW-1:0]      ext_a;
  logic [PW-1:0]      ext_b;
  logic [PW-1:0]      prod_d;
  logic [PW-1:0]      p_q  [PIPELINE];
  logic               pv_q [PIPELINE];
  logic [TAG_W-1:0]   pt_q [PIPELINE];

  // A held output beat freezes the whole pipe; bubbles are never squeezed out.
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  // Operand register: captures the accepted beat, or a bubble when in_valid is low.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      v_q  <= 1'b0;
      se_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      t_q  <= '0;
    end else if (adv) begin
      v_q <= in_valid;
      if (in_valid) begin
        se_q <= signed_en;
        a_q  <= dataa;
        b_q  <= datab;
        t_q  <= in_tag;
      end
    end
  end

  // Extending both operands to the full product width makes the low PW bits exact.
  always_comb begin
    ext_a  = {{(PW - WIDTH_A){se_q & a_q[WIDTH_A-1]}}, a_q};
    ext_b  = {{(PW - WIDTH_B){se_q & b_q[WIDTH_B-1]}}, b_q};
    prod_d = ext_a * ext_b;
  end

  // Product/valid/tag shift registers, advancing together.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < PIPELINE; i++) begin
        p_q[i]  <= '0;
        pv_q[i] <= 1'b0;
        pt_q[i] <= '0;
      end
    end else if (adv) begin
      p_q[0]  <= prod_d;
      pv_q[0] <= v_q;
      pt_q[0] <= t_q;
      for (int i = 1; i < PIPELINE; i++) begin
        p_q[i]  <= p_q[i-1];
        pv_q[i] <= pv_q[i-1];
        pt_q[i] <= pt_q[i-1];
      end
    end
  end

`ifdef MULT_ROUND_SAT_EN
  logic             ps_q [PIPELINE];
  logic [OUT_W-1:0] rs_d;
  logic             sat_d;
  logic [OUT_W-1:0] r_q;
  logic             sat_q;
  logic             ov_q;
  logic [TAG_W-1:0] ot_q;

  // Signedness rides with its product so the clamp range matches the beat.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < PIPELINE; i++) ps_q[i] <= 1'b0;
    end else if (adv) begin
      ps_q[0] <= se_q;
      for (int i = 1; i < PIPELINE; i++) ps_q[i] <= ps_q[i-1];
    end
  end

  mult_round_sat #(
    .PROD_W (PW),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_round_sat (
    .prod_i   (p_q[PIPELINE-1]),
    .signed_i (ps_q[PIPELINE-1]),
    .result_o (rs_d),
    .sat_o    (sat_d)
  );

  // Extra output stage registering the rounded and clamped result.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      ov_q  <= 1'b0;
      r_q   <= '0;
      sat_q <= 1'b0;
      ot_q  <= '0;
    end else if (adv) begin
      ov_q  <= pv_q[PIPELINE-1];
      r_q   <= rs_d;
      sat_q <= sat_d;
      ot_q  <= pt_q[PIPELINE-1];
    end
  end

  assign out_valid = ov_q;
  assign result    = r_q;
  assign out_tag   = ot_q;
  assign sat       = sat_q;
`else
  assign out_valid = pv_q[PIPELINE-1];
  assign result    = OUT_W'(p_q[PIPELINE-1] >> SHIFT);
  assign out_tag   = pt_q[PIPELINE-1];
  assign sat       = 1'b0;
`endif

endmodule

// File: tb/tb_mult_pipe_hs.sv
// tb/tb_mult_pipe_hs.sv - scoreboard bench for mult_pipe_hs (both MULT_ROUND_SAT_EN builds)
module tb_mult_pipe_hs;

  localparam int WA   = 8;
  localparam int WB   = 32;
  localparam int PIPE = 4;
  localparam int TW   = 4;
`ifdef MULT_ROUND_SAT_EN
  localparam int OUT_W = 16;
  localparam int SHIFT = 8;
  localparam int LAT   = PIPE + 1;
`else
  localparam int OUT_W = 40;
  localparam int SHIFT = 0;
  localparam int LAT   = PIPE;
`endif

  logic             clock = 1'b0;
  logic             aclr;
  logic             signed_en;
  logic             in_valid;
  logic             in_ready;
  logic [WA-1:0]    dataa;
  logic [WB-1:0]    datab;
  logic [TW-1:0]    in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] result;
  logic [TW-1:0]    out_tag;
  logic             sat;

  mult_pipe_hs #(
    .WIDTH_A(WA), .WIDTH_B(WB), .OUT_W(OUT_W), .SHIFT(SHIFT), .PIPELINE(PIPE), .TAG_W(TW)
  ) dut (
    .clock(clock), .aclr(aclr), .signed_en(signed_en), .in_valid(in_valid), .in_ready(in_ready),
    .dataa(dataa), .datab(datab), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .sat(sat)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [OUT_W-1:0] res;
    logic [TW-1:0]    tag;
    logic             sat;
  } exp_t;

  typedef struct packed {
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic          se;
    logic [TW-1:0] tag;
    logic [39:0]   edef;
    logic [39:0]   ers;
  } entry_t;

  exp_t   sb_q[$];
  entry_t tbl[8];
  int     total = 0;
  int     bad   = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                 input logic [TW-1:0] tag, input logic se);
    longint pa, pb, p, r, hi, lo;
    exp_t   e;
    pa = se ? longint'($signed(a)) : longint'(a);
    pb = se ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    e.tag = tag;
    e.sat = 1'b0;
`ifdef MULT_ROUND_SAT_EN
    r  = (p + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    hi = se ? (longint'(1) << (OUT_W - 1)) - 1 : (longint'(1) << OUT_W) - 1;
    lo = se ? -(longint'(1) << (OUT_W - 1)) : longint'(0);
    if (r > hi) begin
      r = hi;
      e.sat = 1'b1;
    end else if (r < lo) begin
      r = lo;
      e.sat = 1'b1;
    end
`else
    r  = p >>> SHIFT;
    hi = 0;
    lo = 0;
`endif
    e.res = OUT_W'(r);
    return e;
  endfunction

  // Drive one beat from posedge+1 and retry until it is accepted.
  task automatic send(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic [TW-1:0] tag,
                      input logic se, input bit need_ready);
    bit done = 0;
    bit acc;
    int tries = 0;
    dataa = a; datab = b; in_tag = tag; signed_en = se; in_valid = 1'b1;
    while (!done) begin
      @(negedge clock);
      acc = in_ready;
      if (need_ready) check("in_ready_stream", in_ready, 1);
      @(posedge clock); #1;
      if (acc) begin
        sb_q.push_back(model(a, b, tag, se));
        done = 1;
      end else if (++tries > 100) begin
        check("send_timeout", 0, 1);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  // One beat through an empty pipe: exact latency, then fixed expected result.
  task automatic single(input entry_t e, input string nm);
    logic [39:0] ex;
`ifdef MULT_ROUND_SAT_EN
    ex = e.ers;
`else
    ex = e.edef;
`endif
    send(e.a, e.b, e.tag, e.se, 1'b1);
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clock); @(negedge clock);
      check({nm, "_valid"}, out_valid, (i == LAT));
    end
    check({nm, "_result"}, result, OUT_W'(ex));
    check({nm, "_tag"}, out_tag, e.tag);
    @(posedge clock); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clock);
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
    #1;
  endtask

  // Monitor: scoreboard pop on transfer, stability and in_ready during stalls.
  initial begin
    logic [OUT_W-1:0] held_res;
    logic [TW-1:0]    held_tag;
    bit               holding;
    exp_t             e;
    holding = 0;
    forever begin
      @(negedge clock);
      if (aclr) begin
        holding = 0;
      end else begin
        if (holding) begin
          check("hold_result", result, held_res);
          check("hold_tag", out_tag, held_tag);
        end
        holding = 0;
        if (out_valid && !out_ready) begin
          check("in_ready_stall", in_ready, 0);
          held_res = result;
          held_tag = out_tag;
          holding  = 1;
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("spurious_out", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("result", result, e.res);
            check("out_tag", out_tag, e.tag);
            check("sat", sat, e.sat);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    check("global_timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    tbl[0] = '{a: 8'hFD, b: 32'd1000,       se: 1'b1, tag: 4'd5, edef: 40'hFF_FFFF_F448, ers: 40'hFFF4};
    tbl[1] = '{a: 8'hFF, b: 32'hFFFF_FFFF,  se: 1'b0, tag: 4'd1, edef: 40'hFE_FFFF_FF01, ers: 40'hFFFF};
    tbl[2] = '{a: 8'hFF, b: 32'hFFFF_FFFF,  se: 1'b1, tag: 4'd2, edef: 40'h1,            ers: 40'h0};
    tbl[3] = '{a: 8'h01, b: 32'd384,        se: 1'b1, tag: 4'd3, edef: 40'h180,          ers: 40'h2};
    tbl[4] = '{a: 8'h7F, b: 32'h0001_0000,  se: 1'b1, tag: 4'd4, edef: 40'h7F_0000,      ers: 40'h7F00};
    tbl[5] = '{a: 8'h7F, b: 32'h0010_0000,  se: 1'b1, tag: 4'd6, edef: 40'h7F0_0000,     ers: 40'h7FFF};
    tbl[6] = '{a: 8'h80, b: 32'h0010_0000,  se: 1'b1, tag: 4'd7, edef: 40'hFF_F800_0000, ers: 40'h8000};
    tbl[7] = '{a: 8'h80, b: 32'h0010_0000,  se: 1'b0, tag: 4'd8, edef: 40'h800_0000,     ers: 40'hFFFF};

    aclr = 1'b1; out_ready = 1'b1; in_valid = 1'b0; signed_en = 1'b0;
    dataa = '0; datab = '0; in_tag = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_sat", sat, 0);
    @(posedge clock); #1;
    aclr = 1'b0;
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    @(posedge clock); #1;

    for (int i = 0; i < 8; i++) single(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 16; i++) send(WA'(i), WB'(i + 1), TW'(i), 1'b1, 1'b1);
    drain();

    fork
      begin
        for (int i = 0; i < 24; i++) begin
          send(WA'($urandom), WB'($urandom), TW'(i), $urandom_range(1), 1'b0);
          if ($urandom_range(3) == 0) begin
            @(posedge clock); #1;
          end
        end
      end
      begin
        repeat (6) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (10) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++) send(WA'(i + 2), WB'(7), TW'(i + 9), 1'b1, 1'b1);
    aclr = 1'b1;
    sb_q.delete();
    @(negedge clock);
    check("aclr_out_valid", out_valid, 0);
    @(posedge clock); @(posedge clock); #1;
    aclr = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clock);
      check("post_aclr_idle", out_valid, 0);
    end
    @(posedge clock); #1;
    single(tbl[0], "post_aclr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
